// File: rtl/shift_rotate_pkg.sv
// rtl/shift_rotate_pkg.sv - shared encodings for the iterative shift/rotate unit
package shift_rotate_pkg;

  localparam logic [1:0] MODE_ROT  = 2'b00;
  localparam logic [1:0] MODE_LSH  = 2'b01;
  localparam logic [1:0] MODE_ASH  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational move of a value by k positions (rotate/logical/arithmetic)
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K_W   = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [K_W-1:0]   k,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] dbl_l;
  logic [2*WIDTH-1:0] dbl_r;

  always_comb begin
    // Doubling the operand turns a rotate into a plain shift of the pair.
    dbl_l  = {value, value} << k;
    dbl_r  = {value, value} >> k;
    result = value;
    case (mode)
      MODE_ROT: begin
        if (dir == DIR_LEFT) result = dbl_l[2*WIDTH-1:WIDTH];
        else                 result = dbl_r[WIDTH-1:0];
      end
      MODE_LSH: begin
        if (dir == DIR_RIGHT) result = value >> k;
        else                  result = value << k;
      end
      MODE_ASH: begin
        if (dir == DIR_LEFT) result = value << k;
        else                 result = WIDTH'($signed(value) >>> k);
      end
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// rtl/shift_rotate_seq.sv - iterative shifter/rotator moving up to STEP positions per clock
module shift_rotate_seq
  import shift_rotate_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_en,
  output logic             err
);

  localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] cnt;
  logic             dir_r;
  logic [1:0]       mode_r;
  logic [AMT_W-1:0] k;
  logic [WIDTH-1:0] step_val;
  logic             bad_req;

  assign k       = (cnt > STEP_A) ? STEP_A : cnt;
  assign bad_req = (amount > WIDTH_A) || (mode == MODE_RSVD);

  shift_step #(
    .WIDTH (WIDTH),
    .K_W   (AMT_W)
  ) u_step (
    .value  (work),
    .k      (k),
    .dir    (dir_r),
    .mode   (mode_r),
    .result (step_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      work     <= '0;
      cnt      <= '0;
      dir_r    <= 1'b0;
      mode_r   <= MODE_ROT;
      ready    <= 1'b1;
      data_out <= '0;
      out_en   <= 1'b0;
      err      <= 1'b0;
    end else begin
      out_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_en) begin
            dir_r  <= dir;
            mode_r <= mode;
            ready  <= 1'b0;
            if (bad_req) begin
              work     <= '0;
              cnt      <= '0;
              data_out <= '0;
              err      <= 1'b1;
              out_en   <= 1'b1;
              state    <= ST_DONE;
            end else if (amount == '0) begin
              work     <= data_in;
              cnt      <= '0;
              data_out <= data_in;
              err      <= 1'b0;
              out_en   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              work  <= data_in;
              cnt   <= amount;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          work <= step_val;
          cnt  <= cnt - k;
          // Result registers update on the same edge that enters DONE.
          if (cnt == k) begin
            data_out <= step_val;
            err      <= 1'b0;
            out_en   <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// tb/tb_shift_rotate_seq.sv - scoreboard bench for shift_rotate_seq at 8/1 and 16/4
module tb_shift_rotate_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_op_en = 0, a_dir = 0, a_ready, a_out_en, a_err;
  logic [7:0]  a_data_in = 0, a_data_out;
  logic [3:0]  a_amount = 0;
  logic [1:0]  a_mode = 0;

  logic        b_op_en = 0, b_dir = 0, b_ready, b_out_en, b_err;
  logic [15:0] b_data_in = 0, b_data_out;
  logic [4:0]  b_amount = 0;
  logic [1:0]  b_mode = 0;

  shift_rotate_seq #(.WIDTH(8), .STEP(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .op_en(a_op_en), .data_in(a_data_in),
    .amount(a_amount), .dir(a_dir), .mode(a_mode), .ready(a_ready),
    .data_out(a_data_out), .out_en(a_out_en), .err(a_err)
  );

  shift_rotate_seq #(.WIDTH(16), .STEP(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .op_en(b_op_en), .data_in(b_data_in),
    .amount(b_amount), .dir(b_dir), .mode(b_mode), .ready(b_ready),
    .data_out(b_data_out), .out_en(b_out_en), .err(b_err)
  );

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  last_a = 0;
  logic [15:0] last_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: each result bit is fetched from its source position amt away.
  function automatic exp_t model(input logic [15:0] d, input int amt, input logic dir,
                                 input logic [1:0] mode, input int w, input int step);
    exp_t e;
    e.data = '0;
    e.err  = 1'b0;
    e.acc  = 0;
    if (amt > w || mode == 2'b11) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      for (int j = 0; j < w; j++) begin
        int s;
        s = dir ? j - amt : j + amt;
        if (mode == 2'b00)               e.data[j] = d[(s + w) % w];
        else if (s >= 0 && s < w)        e.data[j] = d[s];
        else if (mode == 2'b10 && !dir)  e.data[j] = d[w-1];
        else                             e.data[j] = 1'b0;
      end
      e.lat = (amt == 0) ? 1 : (amt + step - 1) / step + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      last_a <= '0;
    end else if (a_out_en) begin
      if (q_a.size() == 0) check("a_unexpected_out_en", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_data", {24'b0, a_data_out}, {16'b0, ea.data});
        check("a_err", {31'b0, a_err}, {31'b0, ea.err});
        check("a_latency", cyc - ea.acc + 1, ea.lat);
        check("a_ready_during_done", {31'b0, a_ready}, 0);
      end
      last_a <= a_data_out;
    end else begin
      check("a_data_hold", {24'b0, a_data_out}, {24'b0, last_a});
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      last_b <= '0;
    end else if (b_out_en) begin
      if (q_b.size() == 0) check("b_unexpected_out_en", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_data", {16'b0, b_data_out}, {16'b0, eb.data});
        check("b_err", {31'b0, b_err}, {31'b0, eb.err});
        check("b_latency", cyc - eb.acc + 1, eb.lat);
      end
      last_b <= b_data_out;
    end else begin
      check("b_data_hold", {16'b0, b_data_out}, {16'b0, last_b});
    end
  end

  task automatic issue_a(input logic [7:0] d, input logic [3:0] amt, input logic dir, input logic [1:0] mode);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!a_ready && n < 100) begin @(negedge clk); n++; end
    if (!a_ready) check("a_ready_timeout", 0, 1);
    else begin
      e = model({8'b0, d}, int'(amt), dir, mode, 8, 1);
      e.acc = cyc + 1;
      q_a.push_back(e);
      a_data_in = d; a_amount = amt; a_dir = dir; a_mode = mode; a_op_en = 1'b1;
      @(negedge clk);
      a_op_en = 1'b0;
      check("a_ready_after_accept", {31'b0, a_ready}, 0);
    end
  endtask

  task automatic issue_b(input logic [15:0] d, input logic [4:0] amt, input logic dir, input logic [1:0] mode);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!b_ready && n < 100) begin @(negedge clk); n++; end
    if (!b_ready) check("b_ready_timeout", 0, 1);
    else begin
      e = model(d, int'(amt), dir, mode, 16, 4);
      e.acc = cyc + 1;
      q_b.push_back(e);
      b_data_in = d; b_amount = amt; b_dir = dir; b_mode = mode; b_op_en = 1'b1;
      @(negedge clk);
      b_op_en = 1'b0;
      check("b_ready_after_accept", {31'b0, b_ready}, 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("drain_pending", q_a.size() + q_b.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, a_ready}, 1);
    check("rst_out_en", {31'b0, a_out_en}, 0);
    check("rst_data_out", {24'b0, a_data_out}, 0);
    check("rst_err", {31'b0, a_err}, 0);
    check("rst_b_ready", {31'b0, b_ready}, 1);
    reset_n = 1'b1;

    issue_a(8'hB1, 4'd3, 1'b1, 2'b00);
    issue_a(8'hB1, 4'd3, 1'b0, 2'b00);
    issue_a(8'h90, 4'd2, 1'b0, 2'b10);
    issue_a(8'hFF, 4'd8, 1'b1, 2'b01);
    issue_a(8'hB1, 4'd9, 1'b1, 2'b00);
    issue_a(8'hB1, 4'd2, 1'b0, 2'b11);
    issue_a(8'hB1, 4'd0, 1'b1, 2'b00);
    issue_a(8'hB1, 4'd8, 1'b0, 2'b00);
    issue_a(8'h81, 4'd8, 1'b0, 2'b10);
    issue_a(8'h81, 4'd8, 1'b0, 2'b01);
    drain();

    // Requests presented while busy must be dropped without disturbing the run.
    issue_a(8'hB1, 4'd3, 1'b1, 2'b00);
    a_data_in = 8'h5A; a_amount = 4'd1; a_dir = 1'b0; a_mode = 2'b01; a_op_en = 1'b1;
    @(negedge clk);
    a_op_en = 1'b0;
    drain();

    // Abort mid-run: the pending result is discarded.
    issue_a(8'hFF, 4'd8, 1'b1, 2'b01);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    q_a.delete();
    #1;
    check("abort_ready", {31'b0, a_ready}, 1);
    check("abort_data_out", {24'b0, a_data_out}, 0);
    check("abort_err", {31'b0, a_err}, 0);
    check("abort_out_en", {31'b0, a_out_en}, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    issue_a(8'hB1, 4'd3, 1'b1, 2'b00);
    drain();

    for (int i = 0; i < 120; i++) begin
      logic [3:0] amt;
      amt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      issue_a(8'($urandom), amt, 1'($urandom), 2'($urandom_range(0, 3)));
    end
    drain();

    issue_b(16'h1234, 5'd5, 1'b1, 2'b00);
    issue_b(16'h8001, 5'd16, 1'b0, 2'b10);
    issue_b(16'hBEEF, 5'd17, 1'b1, 2'b01);
    issue_b(16'h1234, 5'd0, 1'b0, 2'b01);
    for (int i = 0; i < 60; i++) begin
      logic [4:0] amt;
      amt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      issue_b(16'($urandom), amt, 1'($urandom), 2'($urandom_range(0, 3)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_rotate_seq.md
# shift_rotate_seq

Iterative, parametrised successor to the combinational 8-bit rotator. Accepts one operand per transaction and applies rotate, logical shift or arithmetic shift left/right by a run-time amount. Processes up to STEP bit positions per clock, trading latency for area. Sits in the datapath behind the operation decoder and presents a one-cycle result strobe to the writeback stage.

## Interface
- WIDTH, 8: operand width in bits (≥2).
- STEP, 1: maximum bit positions processed per clock (1..WIDTH).
- AMT_W, $clog2(WIDTH)+1: width of the amount field; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_en  in  1  request strobe; accepted only when ready=1.
- data_in  in  WIDTH  operand, sampled at accept.
- amount  in  AMT_W  positions to move, sampled at accept.
- dir  in  1  1=left, 0=right, sampled at accept.
- mode  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved.
- ready  out  1  high in IDLE only.
- data_out  out  WIDTH  result register; holds until next completion.
- out_en  out  1  one-cycle completion strobe.
- err  out  1  error flag; valid while out_en=1, held until next completion.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: ready=1. On op_en=1: latch data_in into work register, amount into counter, dir and mode. Go to RUN if amount in 1..WIDTH and mode≠11; else go to DONE.
- Error: amount>WIDTH or mode=11 → DONE with work register forced to 0 and err=1.
- amount=0 → DONE directly, result = data_in, err=0.
- RUN: each cycle move k=min(STEP, counter) positions; counter -= k. When counter reaches 0 after the update, go to DONE.
- Move rules, per k: rotate wraps bits; logical shift fills 0; arithmetic right fills with bit WIDTH-1 of the current work value; arithmetic left is identical to logical left.
- amount=WIDTH: rotate → data_in unchanged; logical → 0; arithmetic right → all bits = original sign.
- DONE: data_out ← work register, err ← error flag, out_en=1 for exactly this cycle, then IDLE.
- op_en while ready=0: ignored, no queuing, no effect on the current operation.
- Reset at any time: abort, return to IDLE, no out_en pulse.

## Timing
- Reset values: data_out=0, out_en=0, err=0, ready=1, counter=0.
- Accept edge = rising edge with op_en=1 and ready=1.
- Normal op: out_en high in cycle ceil(amount/STEP)+1 after accept edge.
- amount=0 or error: out_en high in cycle 1 after accept edge.
- ready falls the cycle after accept and rises the cycle after out_en.
- Minimum spacing between accepts: latency + 1 cycles.
- data_out/err change only on the edge that enters DONE; stable otherwise.

## Structure
- Package shift_rotate_pkg: mode encodings (MODE_ROT, MODE_LSH, MODE_ASH, MODE_RSVD), state enum (ST_IDLE, ST_RUN, ST_DONE), DIR_LEFT/DIR_RIGHT constants.
- Sub-module shift_step: combinational, inputs value[WIDTH], k (0..STEP), dir, mode → value moved by k positions. Top level holds FSM, counter and registers.

## Test plan
- WIDTH=8, STEP=1: data_in=0xB1, amount=3, dir=1, mode=00 → data_out=0x8D, err=0, out_en 4 cycles after accept; same with dir=0 → 0x36.
- WIDTH=8, STEP=1: 0x90, amount=2, dir=0, mode=10 → 0xE4; 0xFF, amount=8, dir=1, mode=01 → 0x00 after 9 cycles.
- WIDTH=8: amount=9 or mode=11 → data_out=0x00, err=1, out_en 1 cycle after accept; amount=0, 0xB1 → 0xB1, err=0, 1 cycle.
- WIDTH=16, STEP=4: 0x1234, amount=5, dir=1, mode=00 → 0x4682, out_en 3 cycles after accept.
- op_en pulsed with new data during RUN → ignored; first result unchanged; ready timing as specified.
- reset_n low mid-RUN → ready=1, data_out=0, err=0, no out_en; next request completes normally.
